// File: rtl/switch_out_arbiter_if.sv
// Request/grant bundle between the input buffers and one switch output arbiter.
// The slave modport is the arbiter's side; the master modport is the requester side.
interface switch_out_arbiter_if #(
   parameter int unsigned PORTS_NUM = 4,
   parameter int unsigned IDX_SIZE  = 3
);
   localparam int unsigned REQ_N = PORTS_NUM + 1;

   logic [REQ_N-1:0]    req_i;
   logic [REQ_N-1:0]    last_i;
   logic                xfer_i;
   logic [REQ_N-1:0]    grant_o;
   logic [IDX_SIZE-1:0] grant_idx_o;
   logic                busy_o;
   logic                timeout_o;

   modport master (
      output req_i, last_i, xfer_i,
      input  grant_o, grant_idx_o, busy_o, timeout_o
   );

   modport slave (
      input  req_i, last_i, xfer_i,
      output grant_o, grant_idx_o, busy_o, timeout_o
   );
endinterface

// File: rtl/switch_out_arbiter.sv
// Round-robin wormhole arbiter for one switch output; locks a requester until its last flit.
// Define ARB_TIMEOUT_EN to add a stall counter that forces release after TIMEOUT idle LOCKED cycles.
module switch_out_arbiter #(
   parameter int unsigned PORTS_NUM = 4,
   parameter int unsigned IDX_SIZE  = 3,
   parameter int unsigned TIMEOUT   = 16
) (
   input logic                  clk,
   input logic                  a_rst,
   switch_out_arbiter_if.slave  bus
);
   localparam int unsigned REQ_N = PORTS_NUM + 1;

   if (IDX_SIZE < $clog2(REQ_N) || TIMEOUT == 0) begin : g_cfg_err
      $error("switch_out_arbiter: IDX_SIZE too small or TIMEOUT is zero");
   end

   typedef enum logic {S_IDLE, S_LOCKED} state_t;

   state_t              state;
   logic [REQ_N-1:0]    grant;
   logic [IDX_SIZE-1:0] grant_idx;
   logic [IDX_SIZE-1:0] rr_ptr;
   logic                busy;
   logic                timeout;

   logic [REQ_N-1:0]    last_vec_c;
   logic [REQ_N-1:0]    cand_c;
   logic [IDX_SIZE-1:0] scan_ptr_c;
   logic [IDX_SIZE-1:0] rel_ptr_c;
   logic [IDX_SIZE-1:0] win_c;
   logic                win_valid_c;
   logic                release_c;
   logic                force_c;
   logic                rel_any_c;

   // First set bit of cand scanning ptr, ptr+1, ... modulo REQ_N.
   function automatic logic [IDX_SIZE-1:0] rr_pick(input logic [REQ_N-1:0] cand,
                                                   input logic [IDX_SIZE-1:0] ptr);
      logic             found;
      logic [REQ_N-1:0] rot;
      int unsigned      j;
      found   = 1'b0;
      rr_pick = '0;
      for (int unsigned k = 0; k < REQ_N; k++) begin
         j   = (32'(ptr) + k) % REQ_N;
         rot = cand >> j;
         if (!found && rot[0]) begin
            found   = 1'b1;
            rr_pick = IDX_SIZE'(j);
         end
      end
   endfunction

   function automatic logic [IDX_SIZE-1:0] ptr_after(input logic [IDX_SIZE-1:0] idx);
      return (idx == IDX_SIZE'(PORTS_NUM)) ? '0 : idx + IDX_SIZE'(1);
   endfunction

`ifdef ARB_TIMEOUT_EN
   localparam int unsigned CNT_W = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
   logic [CNT_W-1:0] stall_cnt;

   assign force_c = (state == S_LOCKED) && !bus.xfer_i &&
                    (stall_cnt == CNT_W'(TIMEOUT - 1));

   // Counts LOCKED cycles without a transfer; any grant change or transfer restarts it.
   always_ff @(posedge clk or posedge a_rst) begin
      if (a_rst) begin
         stall_cnt <= '0;
      end else if (state == S_IDLE || rel_any_c || bus.xfer_i) begin
         stall_cnt <= '0;
      end else begin
         stall_cnt <= stall_cnt + CNT_W'(1);
      end
   end
`else
   assign force_c = 1'b0;
`endif

   // Release detection and candidate selection; on release the holder is masked out.
   always_comb begin
      last_vec_c  = bus.last_i >> grant_idx;
      release_c   = (state == S_LOCKED) && bus.xfer_i && last_vec_c[0];
      rel_any_c   = release_c || force_c;
      rel_ptr_c   = ptr_after(grant_idx);
      cand_c      = bus.req_i;
      scan_ptr_c  = rr_ptr;
      if (state == S_LOCKED) begin
         cand_c     = bus.req_i & ~grant;
         scan_ptr_c = rel_ptr_c;
      end
      win_valid_c = |cand_c;
      win_c       = rr_pick(cand_c, scan_ptr_c);
   end

   always_ff @(posedge clk or posedge a_rst) begin
      if (a_rst) begin
         state     <= S_IDLE;
         grant     <= '0;
         grant_idx <= '0;
         busy      <= 1'b0;
         timeout   <= 1'b0;
         rr_ptr    <= '0;
      end else begin
         timeout <= force_c;
         if (state == S_IDLE || rel_any_c) begin
            if (rel_any_c) begin
               rr_ptr <= rel_ptr_c;
            end
            if (win_valid_c) begin
               state     <= S_LOCKED;
               busy      <= 1'b1;
               grant     <= REQ_N'(1) << win_c;
               grant_idx <= win_c;
            end else begin
               state     <= S_IDLE;
               busy      <= 1'b0;
               grant     <= '0;
               grant_idx <= '0;
            end
         end
      end
   end

   assign bus.grant_o     = grant;
   assign bus.grant_idx_o = grant_idx;
   assign bus.busy_o      = busy;
   assign bus.timeout_o   = timeout;
endmodule

// File: tb/tb_switch_out_arbiter.sv
// Self-checking bench for switch_out_arbiter: stimulus table with a scoreboard queue
// plus hand-written sequences for asynchronous reset and the optional timeout.
module tb_switch_out_arbiter;
   localparam int unsigned PN = 4;
   localparam int unsigned IW = 3;
   localparam int unsigned RN = PN + 1;

   typedef struct {
      bit          rst;
      logic [RN-1:0] req;
      logic [RN-1:0] last;
      logic        xfer;
      logic        busy;
      logic [IW-1:0] idx;
      logic        to;
   } vec_t;

   typedef struct {
      logic        busy;
      logic [IW-1:0] idx;
      logic        to;
   } exp_t;

   logic clk = 1'b0;
   logic a_rst;
   int   n_checks = 0;
   int   n_errors = 0;
   vec_t vecs[$];
   exp_t exp_q[$];

   always #5 clk = ~clk;

   switch_out_arbiter_if #(.PORTS_NUM(PN), .IDX_SIZE(IW)) bus ();

   switch_out_arbiter #(.PORTS_NUM(PN), .IDX_SIZE(IW), .TIMEOUT(16)) dut (
      .clk   (clk),
      .a_rst (a_rst),
      .bus   (bus)
   );

   function automatic vec_t mk(bit rst, logic [RN-1:0] req, logic [RN-1:0] last, logic xfer,
                               logic busy, logic [IW-1:0] idx, logic to);
      vec_t v;
      v.rst = rst; v.req = req; v.last = last; v.xfer = xfer;
      v.busy = busy; v.idx = idx; v.to = to;
      return v;
   endfunction

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_errors++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   task automatic check_outputs(input string tag, input logic busy, input logic [IW-1:0] idx,
                                input logic to);
      logic [RN-1:0] one;
      logic [RN-1:0] exp_grant;
      one       = 1;
      exp_grant = busy ? (one << idx) : '0;
      chk({tag, " grant"},   32'(bus.grant_o),     32'(exp_grant));
      chk({tag, " idx"},     32'(bus.grant_idx_o), 32'(busy ? idx : '0));
      chk({tag, " busy"},    32'(bus.busy_o),      32'(busy));
      chk({tag, " timeout"}, 32'(bus.timeout_o),   32'(to));
   endtask

   task automatic drive(input logic [RN-1:0] req, input logic [RN-1:0] last, input logic xfer);
      bus.req_i  = req;
      bus.last_i = last;
      bus.xfer_i = xfer;
   endtask

   task automatic apply_reset(input string tag);
      @(negedge clk);
      a_rst = 1'b1;
      drive('0, '0, 1'b0);
      #1;
      check_outputs({tag, " in reset"}, 1'b0, '0, 1'b0);
      @(negedge clk);
      a_rst = 1'b0;
   endtask

   // Drive one cycle, queue the expected post-edge outputs, then pop and compare after the edge.
   task automatic run_step(input vec_t v, input string tag);
      exp_t e;
      if (v.rst) apply_reset(tag);
      @(negedge clk);
      drive(v.req, v.last, v.xfer);
      e.busy = v.busy; e.idx = v.idx; e.to = v.to;
      exp_q.push_back(e);
      @(posedge clk);
      #1;
      if (exp_q.size() == 0) begin
         chk({tag, " scoreboard empty"}, 32'd0, 32'd1);
      end else begin
         e = exp_q.pop_front();
         check_outputs(tag, e.busy, e.idx, e.to);
      end
   endtask

   initial begin
      // single packet on input 2, three grant cycles, then rr_ptr must point at 3
      vecs.push_back(mk(1, 5'b00100, 5'b00000, 0, 1, 2, 0));
      vecs.push_back(mk(0, 5'b00100, 5'b00000, 0, 1, 2, 0));
      vecs.push_back(mk(0, 5'b00100, 5'b00100, 0, 1, 2, 0));
      vecs.push_back(mk(0, 5'b00100, 5'b00100, 1, 0, 0, 0));
      vecs.push_back(mk(0, 5'b00000, 5'b00000, 0, 0, 0, 0));
      vecs.push_back(mk(0, 5'b11111, 5'b00000, 0, 1, 3, 0));
      // all five requesting, 2-flit packets, back-to-back
      vecs.push_back(mk(1, 5'b11111, 5'b00000, 0, 1, 0, 0));
      vecs.push_back(mk(0, 5'b11111, 5'b00000, 1, 1, 0, 0));
      vecs.push_back(mk(0, 5'b11111, 5'b11111, 1, 1, 1, 0));
      vecs.push_back(mk(0, 5'b11111, 5'b00000, 1, 1, 1, 0));
      vecs.push_back(mk(0, 5'b11111, 5'b11111, 1, 1, 2, 0));
      vecs.push_back(mk(0, 5'b11111, 5'b00000, 1, 1, 2, 0));
      vecs.push_back(mk(0, 5'b11111, 5'b11111, 1, 1, 3, 0));
      vecs.push_back(mk(0, 5'b11111, 5'b00000, 1, 1, 3, 0));
      vecs.push_back(mk(0, 5'b11111, 5'b11111, 1, 1, 4, 0));
      vecs.push_back(mk(0, 5'b11111, 5'b00000, 1, 1, 4, 0));
      vecs.push_back(mk(0, 5'b11111, 5'b11111, 1, 1, 0, 0));
      vecs.push_back(mk(0, 5'b11111, 5'b00000, 1, 1, 0, 0));
      vecs.push_back(mk(0, 5'b00000, 5'b11111, 1, 0, 0, 0));
      vecs.push_back(mk(0, 5'b00000, 5'b11111, 1, 0, 0, 0));
      // granted input 1 drops req mid-packet; only xfer with last_i[1] releases it
      vecs.push_back(mk(0, 5'b00011, 5'b00000, 0, 1, 1, 0));
      vecs.push_back(mk(0, 5'b00001, 5'b00000, 1, 1, 1, 0));
      vecs.push_back(mk(0, 5'b00001, 5'b00011, 0, 1, 1, 0));
      vecs.push_back(mk(0, 5'b00001, 5'b00001, 1, 1, 1, 0));
      vecs.push_back(mk(0, 5'b00001, 5'b00010, 1, 1, 0, 0));
      vecs.push_back(mk(0, 5'b00000, 5'b00001, 1, 0, 0, 0));
      // move rr_ptr to 4, then 1-flit packets from inputs 0 and 1 wrap around
      vecs.push_back(mk(0, 5'b01000, 5'b00000, 0, 1, 3, 0));
      vecs.push_back(mk(0, 5'b00000, 5'b01000, 1, 0, 0, 0));
      vecs.push_back(mk(0, 5'b00011, 5'b00000, 0, 1, 0, 0));
      vecs.push_back(mk(0, 5'b00010, 5'b00011, 1, 1, 1, 0));
      vecs.push_back(mk(0, 5'b00000, 5'b00011, 1, 0, 0, 0));
`ifdef ARB_TIMEOUT_EN
      // stalled grant on 2 is forced off on the 16th stall edge and handed to 1
      vecs.push_back(mk(1, 5'b00100, 5'b00000, 0, 1, 2, 0));
      for (int i = 0; i < 15; i++) vecs.push_back(mk(0, 5'b00110, 5'b00000, 0, 1, 2, 0));
      vecs.push_back(mk(0, 5'b00110, 5'b00000, 0, 1, 1, 1));
      vecs.push_back(mk(0, 5'b00100, 5'b00010, 1, 1, 2, 0));
      vecs.push_back(mk(0, 5'b00000, 5'b00100, 1, 0, 0, 0));
`endif

      a_rst = 1'b1;
      drive('0, '0, 1'b0);
      repeat (2) @(posedge clk);
      #1;
      check_outputs("power-on reset", 1'b0, '0, 1'b0);

      for (int i = 0; i < vecs.size(); i++) begin
         run_step(vecs[i], $sformatf("vec%0d", i));
      end

      // asynchronous reset between edges mid-packet clears outputs without a clock edge
      apply_reset("async");
      run_step(mk(0, 5'b01000, 5'b00000, 0, 1, 3, 0), "async pre1");
      run_step(mk(0, 5'b01000, 5'b00000, 0, 1, 3, 0), "async pre2");
      #2;
      a_rst = 1'b1;
      #1;
      check_outputs("async mid-cycle", 1'b0, '0, 1'b0);
      @(negedge clk);
      drive('0, '0, 1'b0);
      a_rst = 1'b0;
      run_step(mk(0, 5'b10000, 5'b00000, 0, 1, 4, 0), "async post");
      run_step(mk(0, 5'b10000, 5'b10000, 1, 0, 0, 0), "async release");

      chk("scoreboard drained", 32'(exp_q.size()), 32'd0);
      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end
endmodule
